// File: rtl/pc_flag_sequencer_pkg.sv
// Shared types and default widths for the PC / flag sequencer.
package pc_flag_sequencer_pkg;

  localparam int PC_W_DEF   = 10;
  localparam int LUT_AW_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pc_flag_sequencer_branch_lut.sv
// Branch-target table: 2**LUT_AW entries of absolute PCs, synchronous write and
// clear, combinational read.
module pc_flag_sequencer_branch_lut
  import pc_flag_sequencer_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [LUT_AW-1:0] waddr,
  input  logic [PC_W-1:0]   wdata,
  input  logic [LUT_AW-1:0] raddr,
  output logic [PC_W-1:0]   rdata
);

  logic [PC_W-1:0] mem [2**LUT_AW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**LUT_AW; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_flag_sequencer.sv
// Program sequencer: owns PC, FLAG and OVERFLOW for the ALU, selects the next PC
// (sequential or table branch) and runs the START -> RUN -> DONE handshake.
module pc_flag_sequencer
  import pc_flag_sequencer_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [PC_W-1:0]   START_ADDR,
  input  logic              INSTR_HALT,
  input  logic [LUT_AW-1:0] BR_IDX,
  input  logic              ALU_FLAG_OUT,
  input  logic              ALU_OVERFLOW_OUT,
  input  logic              FLAG_BRANCH_EN,
  input  logic              LUT_WE,
  input  logic [LUT_AW-1:0] LUT_WADDR,
  input  logic [PC_W-1:0]   LUT_WDATA,
  output logic [PC_W-1:0]   PC,
  output logic              FLAG_IN,
  output logic              OVERFLOW_IN,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  CYCLE_CT
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             flag_q, flag_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  lut_target;
  logic             lut_we_ok;

  // Table is frozen while a program is executing.
  assign lut_we_ok = LUT_WE && (state_q != ST_RUN);

  pc_flag_sequencer_branch_lut #(
    .PC_W   (PC_W),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk   (CLK),
    .rst_n (RESET_N),
    .we    (lut_we_ok),
    .waddr (LUT_WADDR),
    .wdata (LUT_WDATA),
    .raddr (BR_IDX),
    .rdata (lut_target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        cnt_d = sat_inc(cnt_q);
        // Halt takes priority over a simultaneous branch and freezes the flags.
        if (INSTR_HALT) begin
          state_d = ST_DONE;
        end else begin
          flag_d = ALU_FLAG_OUT;
          ovf_d  = ALU_OVERFLOW_OUT;
          pc_d   = FLAG_BRANCH_EN ? lut_target : pc_q + PC_W'(1);
        end
      end
      default: begin
        if (START) begin
          state_d = ST_RUN;
          pc_d    = START_ADDR;
          flag_d  = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC          = pc_q;
  assign FLAG_IN     = flag_q;
  assign OVERFLOW_IN = ovf_q;
  assign BUSY        = (state_q == ST_RUN);
  assign DONE        = (state_q == ST_DONE);
  assign CYCLE_CT    = cnt_q;

endmodule

// File: tb/tb_pc_flag_sequencer.sv
// Directed bench for pc_flag_sequencer with hand-computed expectations.
module tb_pc_flag_sequencer;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 4;
  localparam int CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              START;
  logic [PC_W-1:0]   START_ADDR;
  logic              INSTR_HALT;
  logic [LUT_AW-1:0] BR_IDX;
  logic              ALU_FLAG_OUT;
  logic              ALU_OVERFLOW_OUT;
  logic              FLAG_BRANCH_EN;
  logic              LUT_WE;
  logic [LUT_AW-1:0] LUT_WADDR;
  logic [PC_W-1:0]   LUT_WDATA;
  logic [PC_W-1:0]   PC;
  logic              FLAG_IN;
  logic              OVERFLOW_IN;
  logic              BUSY;
  logic              DONE;
  logic [CNT_W-1:0]  CYCLE_CT;

  int n_cmp = 0;
  int n_bad = 0;

  pc_flag_sequencer #(
    .PC_W   (PC_W),
    .LUT_AW (LUT_AW),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .START            (START),
    .START_ADDR       (START_ADDR),
    .INSTR_HALT       (INSTR_HALT),
    .BR_IDX           (BR_IDX),
    .ALU_FLAG_OUT     (ALU_FLAG_OUT),
    .ALU_OVERFLOW_OUT (ALU_OVERFLOW_OUT),
    .FLAG_BRANCH_EN   (FLAG_BRANCH_EN),
    .LUT_WE           (LUT_WE),
    .LUT_WADDR        (LUT_WADDR),
    .LUT_WDATA        (LUT_WDATA),
    .PC               (PC),
    .FLAG_IN          (FLAG_IN),
    .OVERFLOW_IN      (OVERFLOW_IN),
    .BUSY             (BUSY),
    .DONE             (DONE),
    .CYCLE_CT         (CYCLE_CT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    START = 0; START_ADDR = '0; INSTR_HALT = 0; BR_IDX = '0;
    ALU_FLAG_OUT = 0; ALU_OVERFLOW_OUT = 0; FLAG_BRANCH_EN = 0;
    LUT_WE = 0; LUT_WADDR = '0; LUT_WDATA = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET_N = 0;
    tick(); tick();
    n_cmp++; if (PC !== 10'h000) begin n_bad++; $display("FAIL reset_pc got %h want 000", PC); end
    n_cmp++; if (FLAG_IN !== 1'b0) begin n_bad++; $display("FAIL reset_flag got %b want 0", FLAG_IN); end
    n_cmp++; if (OVERFLOW_IN !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", OVERFLOW_IN); end
    n_cmp++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done got %b%b want 00", BUSY, DONE); end
    n_cmp++; if (CYCLE_CT !== 4'd0) begin n_bad++; $display("FAIL reset_ct got %0d want 0", CYCLE_CT); end
    RESET_N = 1;
    tick();
    n_cmp++; if (BUSY !== 1'b0 || PC !== 10'h000) begin n_bad++; $display("FAIL idle_hold busy %b pc %h want 0 000", BUSY, PC); end
  endtask

  task automatic test_lut_branch();
    // Table write and START in the same IDLE cycle.
    LUT_WE = 1; LUT_WADDR = 4'd3; LUT_WDATA = 10'h040;
    START = 1; START_ADDR = 10'h010;
    tick();
    idle_inputs();
    n_cmp++; if (PC !== 10'h010 || BUSY !== 1'b1) begin n_bad++; $display("FAIL start_pc got %h busy %b want 010 1", PC, BUSY); end
    n_cmp++; if (CYCLE_CT !== 4'd0) begin n_bad++; $display("FAIL start_ct got %0d want 0", CYCLE_CT); end
    tick();
    n_cmp++; if (PC !== 10'h011) begin n_bad++; $display("FAIL seq_pc1 got %h want 011", PC); end
    tick();
    n_cmp++; if (PC !== 10'h012 || CYCLE_CT !== 4'd2) begin n_bad++; $display("FAIL seq_pc2 got %h ct %0d want 012 2", PC, CYCLE_CT); end
    FLAG_BRANCH_EN = 1; BR_IDX = 4'd3;
    tick();
    FLAG_BRANCH_EN = 0; BR_IDX = '0;
    n_cmp++; if (PC !== 10'h040) begin n_bad++; $display("FAIL branch_pc got %h want 040", PC); end
  endtask

  task automatic test_flags();
    ALU_OVERFLOW_OUT = 1;
    tick();
    n_cmp++; if (OVERFLOW_IN !== 1'b1 || FLAG_IN !== 1'b0) begin n_bad++; $display("FAIL ovf_latency got o%b f%b want o1 f0", OVERFLOW_IN, FLAG_IN); end
    ALU_OVERFLOW_OUT = 0; ALU_FLAG_OUT = 1;
    tick();
    n_cmp++; if (FLAG_IN !== 1'b1 || OVERFLOW_IN !== 1'b0) begin n_bad++; $display("FAIL flag_latency got f%b o%b want f1 o0", FLAG_IN, OVERFLOW_IN); end
    ALU_FLAG_OUT = 0;
    tick();
    n_cmp++; if (FLAG_IN !== 1'b0 || PC !== 10'h043) begin n_bad++; $display("FAIL flag_clear got f%b pc %h want f0 043", FLAG_IN, PC); end
    INSTR_HALT = 1;
    tick();
    INSTR_HALT = 0;
    n_cmp++; if (DONE !== 1'b1 || BUSY !== 1'b0 || PC !== 10'h043) begin n_bad++; $display("FAIL halt1 got done %b busy %b pc %h want 1 0 043", DONE, BUSY, PC); end
  endtask

  task automatic test_wrap();
    START = 1; START_ADDR = 10'h3FF;
    tick();
    START = 0;
    n_cmp++; if (PC !== 10'h3FF || DONE !== 1'b0) begin n_bad++; $display("FAIL wrap_start got %h done %b want 3ff 0", PC, DONE); end
    tick();
    n_cmp++; if (PC !== 10'h000 || BUSY !== 1'b1) begin n_bad++; $display("FAIL wrap_pc got %h busy %b want 000 1", PC, BUSY); end
    INSTR_HALT = 1;
    tick();
    INSTR_HALT = 0;
  endtask

  task automatic test_halt();
    START = 1; START_ADDR = 10'h100;
    tick();
    START = 0;
    n_cmp++; if (CYCLE_CT !== 4'd0) begin n_bad++; $display("FAIL restart_ct got %0d want 0", CYCLE_CT); end
    for (int i = 0; i < 7; i++) tick();
    n_cmp++; if (PC !== 10'h107 || CYCLE_CT !== 4'd7) begin n_bad++; $display("FAIL run7 got %h ct %0d want 107 7", PC, CYCLE_CT); end
    INSTR_HALT = 1; FLAG_BRANCH_EN = 1; BR_IDX = 4'd3; ALU_FLAG_OUT = 1; ALU_OVERFLOW_OUT = 1;
    tick();
    idle_inputs();
    n_cmp++; if (DONE !== 1'b1 || PC !== 10'h107) begin n_bad++; $display("FAIL halt_branch got done %b pc %h want 1 107", DONE, PC); end
    n_cmp++; if (CYCLE_CT !== 4'd8) begin n_bad++; $display("FAIL halt_ct got %0d want 8", CYCLE_CT); end
    n_cmp++; if (FLAG_IN !== 1'b0 || OVERFLOW_IN !== 1'b0) begin n_bad++; $display("FAIL halt_flags got f%b o%b want 0 0", FLAG_IN, OVERFLOW_IN); end
    tick();
    n_cmp++; if (DONE !== 1'b1 || CYCLE_CT !== 4'd8 || PC !== 10'h107) begin n_bad++; $display("FAIL done_hold got done %b ct %0d pc %h want 1 8 107", DONE, CYCLE_CT, PC); end
  endtask

  task automatic test_run_ignores();
    START = 1; START_ADDR = 10'h020;
    tick();
    // START and LUT_WE while running must both be ignored.
    START_ADDR = 10'h300; LUT_WE = 1; LUT_WADDR = 4'd3; LUT_WDATA = 10'h2AA;
    tick();
    idle_inputs();
    n_cmp++; if (PC !== 10'h021 || BUSY !== 1'b1) begin n_bad++; $display("FAIL start_in_run got %h busy %b want 021 1", PC, BUSY); end
    FLAG_BRANCH_EN = 1; BR_IDX = 4'd3;
    tick();
    FLAG_BRANCH_EN = 0;
    n_cmp++; if (PC !== 10'h040) begin n_bad++; $display("FAIL lut_frozen got %h want 040", PC); end
    INSTR_HALT = 1;
    tick();
    INSTR_HALT = 0;
    n_cmp++; if (DONE !== 1'b1 || CYCLE_CT !== 4'd3) begin n_bad++; $display("FAIL halt2 got done %b ct %0d want 1 3", DONE, CYCLE_CT); end
  endtask

  task automatic test_back_to_back();
    // Write in DONE together with START; first RUN cycle branches through it.
    LUT_WE = 1; LUT_WADDR = 4'd5; LUT_WDATA = 10'h155;
    START = 1; START_ADDR = 10'h000;
    tick();
    idle_inputs();
    n_cmp++; if (DONE !== 1'b0 || CYCLE_CT !== 4'd0 || BUSY !== 1'b1) begin n_bad++; $display("FAIL restart_done got done %b ct %0d busy %b want 0 0 1", DONE, CYCLE_CT, BUSY); end
    FLAG_BRANCH_EN = 1; BR_IDX = 4'd5;
    tick();
    FLAG_BRANCH_EN = 0;
    n_cmp++; if (PC !== 10'h155) begin n_bad++; $display("FAIL first_cycle_branch got %h want 155", PC); end
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (CYCLE_CT !== 4'hF || BUSY !== 1'b1) begin n_bad++; $display("FAIL ct_saturate got %0d busy %b want 15 1", CYCLE_CT, BUSY); end
    INSTR_HALT = 1;
    tick();
    INSTR_HALT = 0;
    n_cmp++; if (CYCLE_CT !== 4'hF || DONE !== 1'b1) begin n_bad++; $display("FAIL ct_sat_halt got %0d done %b want 15 1", CYCLE_CT, DONE); end
  endtask

  task automatic test_reset_mid_run();
    START = 1; START_ADDR = 10'h003;
    tick();
    START = 0;
    tick();
    ALU_FLAG_OUT = 1;
    tick();
    ALU_FLAG_OUT = 0;
    n_cmp++; if (PC !== 10'h005 || FLAG_IN !== 1'b1) begin n_bad++; $display("FAIL pre_reset got %h f%b want 005 1", PC, FLAG_IN); end
    RESET_N = 0; START = 1; LUT_WE = 1; ALU_FLAG_OUT = 1;
    tick();
    idle_inputs();
    RESET_N = 1;
    n_cmp++; if (PC !== 10'h000 || FLAG_IN !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || CYCLE_CT !== 4'd0)
      begin n_bad++; $display("FAIL mid_reset got pc %h f%b b%b d%b ct %0d want 000 0 0 0 0", PC, FLAG_IN, BUSY, DONE, CYCLE_CT); end
    // Every table entry must read back as zero: branching to it lands on PC 0.
    START = 1; START_ADDR = 10'h0AB;
    tick();
    START = 0;
    for (int i = 0; i < 16; i++) begin
      FLAG_BRANCH_EN = 1; BR_IDX = LUT_AW'(i);
      tick();
      n_cmp++; if (PC !== 10'h000) begin n_bad++; $display("FAIL lut_cleared idx %0d got %h want 000", i, PC); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_lut_branch();
    test_flags();
    test_wrap();
    test_halt();
    test_run_ignores();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
